// File: rtl/microwave_ctrl.sv
// Microwave sequencer: picks cook time, pulses the timer, enforces the door interlock, duty-cycles the magnetron and beeps on completion.
// Latency: timer pulses appear 1 cycle after a button rises; no backpressure (timer accepts every pulse).
module microwave_ctrl #(
    parameter int unsigned PWR_PERIOD  = 100000000,
    parameter int unsigned BEEP_CYCLES = 150000000,
    parameter int unsigned ARM_TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       door_open,
    input  logic [1:0] preset,
    input  logic [1:0] power,
    input  logic [6:0] sw_min,
    input  logic [6:0] sw_sec,
    input  logic       timer_done,
    output logic       timer_start,
    output logic       timer_pause,
    output logic       timer_stop,
    output logic [6:0] min_set,
    output logic [6:0] sec_set,
    output logic       magnetron,
    output logic       lamp,
    output logic       beep
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_COOK,
        ST_PAUSE,
        ST_DONE
    } state_t;

    localparam logic [31:0] WIN_LAST  = 32'(PWR_PERIOD - 1);
    localparam logic [31:0] WIN_QTR   = 32'(PWR_PERIOD / 4);
    localparam logic [31:0] BEEP_LAST = 32'(BEEP_CYCLES - 1);
    localparam logic [31:0] ARM_LAST  = 32'(ARM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        start_prev_q, stop_prev_q, ev_en_q;
    logic        start_ev, stop_ev;
    logic [31:0] win_q, win_d;
    logic [31:0] arm_cnt_q, arm_cnt_d;
    logic [31:0] beep_cnt_q, beep_cnt_d;
    logic [1:0]  pwr_q, pwr_d;
    logic [6:0]  min_q, min_d, sec_q, sec_d;
    logic [6:0]  sel_min, sel_sec;
    logic        start_pls_q, start_pls_d;
    logic        pause_pls_q, pause_pls_d;
    logic        stop_pls_q, stop_pls_d;
    logic [31:0] mag_thr;

    // ev_en_q masks the first cycle after reset so a button held through reset is not taken as a press.
    assign start_ev = ev_en_q & start_btn & ~start_prev_q;
    assign stop_ev  = ev_en_q & stop_btn & ~stop_prev_q;

    always_comb begin
        sel_min = 7'd0;
        sel_sec = 7'd0;
        case (preset)
            2'd0: begin
                sel_min = (sw_min > 7'd99) ? 7'd99 : sw_min;
                sel_sec = (sw_sec > 7'd59) ? 7'd59 : sw_sec;
            end
            2'd1: sel_sec = 7'd30;
            2'd2: sel_min = 7'd1;
            default: sel_min = 7'd2;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        arm_cnt_d   = arm_cnt_q;
        beep_cnt_d  = beep_cnt_q;
        pwr_d       = pwr_q;
        min_d       = min_q;
        sec_d       = sec_q;
        start_pls_d = 1'b0;
        pause_pls_d = 1'b0;
        stop_pls_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                min_d = sel_min;
                sec_d = sel_sec;
                if (start_ev && !door_open) begin
                    start_pls_d = 1'b1;
                    pwr_d       = power;
                    arm_cnt_d   = 32'd0;
                    state_d     = ST_ARM;
                end
            end
            ST_ARM: begin
                if (stop_ev) begin
                    stop_pls_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (!timer_done) begin
                    win_d   = 32'd0;
                    state_d = ST_COOK;
                end else if (arm_cnt_q == ARM_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    arm_cnt_d = arm_cnt_q + 32'd1;
                end
            end
            ST_COOK: begin
                win_d = (win_q == WIN_LAST) ? 32'd0 : win_q + 32'd1;
                if (stop_ev) begin
                    stop_pls_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (door_open) begin
                    pause_pls_d = 1'b1;
                    state_d     = ST_PAUSE;
                end else if (timer_done) begin
                    beep_cnt_d = 32'd0;
                    state_d    = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (stop_ev) begin
                    stop_pls_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (start_ev && !door_open) begin
                    // The timer's pause input toggles, so the same pulse resumes it.
                    pause_pls_d = 1'b1;
                    win_d       = 32'd0;
                    state_d     = ST_COOK;
                end
            end
            ST_DONE: begin
                if (start_ev || stop_ev) begin
                    state_d = ST_IDLE;
                end else if (beep_cnt_q == BEEP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    beep_cnt_d = beep_cnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
            ev_en_q      <= 1'b0;
            win_q        <= 32'd0;
            arm_cnt_q    <= 32'd0;
            beep_cnt_q   <= 32'd0;
            pwr_q        <= 2'd0;
            min_q        <= 7'd0;
            sec_q        <= 7'd0;
            start_pls_q  <= 1'b0;
            pause_pls_q  <= 1'b0;
            stop_pls_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_btn;
            stop_prev_q  <= stop_btn;
            ev_en_q      <= 1'b1;
            win_q        <= win_d;
            arm_cnt_q    <= arm_cnt_d;
            beep_cnt_q   <= beep_cnt_d;
            pwr_q        <= pwr_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            start_pls_q  <= start_pls_d;
            pause_pls_q  <= pause_pls_d;
            stop_pls_q   <= stop_pls_d;
        end
    end

    assign mag_thr = WIN_QTR * ({30'd0, pwr_q} + 32'd1);

    // Door gating is combinational so the heater drops in the very cycle the door opens.
    assign magnetron   = (state_q == ST_COOK) & ~door_open & ((pwr_q == 2'd3) | (win_q < mag_thr));
    assign lamp        = reset & ((state_q == ST_COOK) | (state_q == ST_PAUSE) | door_open);
    assign beep        = (state_q == ST_DONE);
    assign timer_start = start_pls_q;
    assign timer_pause = pause_pls_q;
    assign timer_stop  = stop_pls_q;
    assign min_set     = min_q;
    assign sec_set     = sec_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Bench for microwave_ctrl: directed scenarios plus random stimulus against a cycle-level reference model.
module tb_microwave_ctrl;

    localparam int P = 8;
    localparam int B = 20;
    localparam int A = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start_btn = 1'b0, stop_btn = 1'b0, door_open = 1'b0, timer_done = 1'b1;
    logic [1:0] preset = 2'd0, power = 2'd0;
    logic [6:0] sw_min = 7'd0, sw_sec = 7'd0;
    logic       timer_start, timer_pause, timer_stop, magnetron, lamp, beep;
    logic [6:0] min_set, sec_set;

    microwave_ctrl #(.PWR_PERIOD(P), .BEEP_CYCLES(B), .ARM_TIMEOUT(A)) dut (
        .clock(clock), .reset(reset), .start_btn(start_btn), .stop_btn(stop_btn),
        .door_open(door_open), .preset(preset), .power(power), .sw_min(sw_min),
        .sw_sec(sw_sec), .timer_done(timer_done), .timer_start(timer_start),
        .timer_pause(timer_pause), .timer_stop(timer_stop), .min_set(min_set),
        .sec_set(sec_set), .magnetron(magnetron), .lamp(lamp), .beep(beep)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a named mode plus elapsed-cycle counters.
    string mode;
    int    t_cook, arm_n, beep_n, plat, e_min, e_sec;
    bit    alive, pb_start, pb_stop, e_start, e_pause, e_stop;

    task automatic model_reset();
        mode = "idle";
        t_cook = 0; arm_n = 0; beep_n = 0; plat = 0; e_min = 0; e_sec = 0;
        alive = 0; pb_start = 0; pb_stop = 0;
        e_start = 0; e_pause = 0; e_stop = 0;
    endtask

    task automatic model_edge();
        bit es, ep;
        es = alive && start_btn && !pb_start;
        ep = alive && stop_btn && !pb_stop;
        pb_start = start_btn;
        pb_stop  = stop_btn;
        alive    = 1;
        e_start = 0; e_pause = 0; e_stop = 0;
        if (mode == "idle") begin
            case (preset)
                2'd0: begin
                    e_min = (int'(sw_min) > 99) ? 99 : int'(sw_min);
                    e_sec = (int'(sw_sec) > 59) ? 59 : int'(sw_sec);
                end
                2'd1: begin e_min = 0; e_sec = 30; end
                2'd2: begin e_min = 1; e_sec = 0; end
                default: begin e_min = 2; e_sec = 0; end
            endcase
            if (es && !door_open) begin
                e_start = 1; plat = int'(power); arm_n = 0; mode = "arm";
            end
        end else if (mode == "arm") begin
            if (ep) begin e_stop = 1; mode = "idle"; end
            else if (!timer_done) begin mode = "cook"; t_cook = 0; end
            else begin
                arm_n++;
                if (arm_n >= A) mode = "idle";
            end
        end else if (mode == "cook") begin
            if (ep) begin e_stop = 1; mode = "idle"; end
            else if (door_open) begin e_pause = 1; mode = "pause"; end
            else if (timer_done) begin mode = "done"; beep_n = 0; end
            else t_cook++;
        end else if (mode == "pause") begin
            if (ep) begin e_stop = 1; mode = "idle"; end
            else if (es && !door_open) begin e_pause = 1; mode = "cook"; t_cook = 0; end
        end else begin
            if (es || ep) mode = "idle";
            else begin
                beep_n++;
                if (beep_n >= B) mode = "idle";
            end
        end
    endtask

    task automatic check_all(input string ph);
        bit em, el;
        em = reset && (mode == "cook") && !door_open &&
             (plat == 3 || (t_cook % P) < (P / 4) * (plat + 1));
        el = reset && ((mode == "cook") || (mode == "pause") || door_open);
        check_val({ph, ":start"}, 32'(timer_start), 32'(e_start));
        check_val({ph, ":pause"}, 32'(timer_pause), 32'(e_pause));
        check_val({ph, ":stop"},  32'(timer_stop),  32'(e_stop));
        check_val({ph, ":min"},   32'(min_set),     32'(e_min));
        check_val({ph, ":sec"},   32'(sec_set),     32'(e_sec));
        check_val({ph, ":mag"},   32'(magnetron),   32'(em));
        check_val({ph, ":lamp"},  32'(lamp),        32'(el));
        check_val({ph, ":beep"},  32'(beep),        32'(mode == "done"));
    endtask

    string phase = "rst";
    int mag_cnt, beep_cnt;

    task automatic cyc();
        @(posedge clock);
        if (reset) model_edge();
        else model_reset();
        @(negedge clock);
        check_all(phase);
        if (magnetron) mag_cnt++;
        if (beep) beep_cnt++;
    endtask

    task automatic press_start();
        start_btn = 1'b1; cyc();
        start_btn = 1'b0; cyc();
    endtask

    task automatic press_stop();
        stop_btn = 1'b1; cyc();
        stop_btn = 1'b0; cyc();
    endtask

    initial begin
        model_reset();
        repeat (2) cyc();
        reset = 1'b1;
        repeat (2) cyc();

        // Preset 1, full power, complete cook cycle with beep.
        phase = "p1"; preset = 2'd1; power = 2'd3;
        repeat (2) cyc();
        press_start();
        timer_done = 1'b0; cyc();
        mag_cnt = 0;
        repeat (12) cyc();
        check_val("p1_mag_full", 32'(mag_cnt), 32'd12);
        timer_done = 1'b1; beep_cnt = 0;
        repeat (B + 4) cyc();
        check_val("p1_beep_len", 32'(beep_cnt), 32'(B));

        // Manual clamp and 50% duty.
        phase = "man"; preset = 2'd0; sw_min = 7'd120; sw_sec = 7'd75; power = 2'd1;
        repeat (2) cyc();
        check_val("man_min", 32'(min_set), 32'd99);
        check_val("man_sec", 32'(sec_set), 32'd59);
        press_start();
        timer_done = 1'b0; cyc();
        mag_cnt = 0;
        repeat (2 * P) cyc();
        check_val("man_duty", 32'(mag_cnt), 32'(P));

        // Door open mid-cook, blocked resume, then resume.
        phase = "door";
        door_open = 1'b1; cyc();
        cyc();
        press_start();
        door_open = 1'b0; cyc();
        press_start();
        repeat (5) cyc();

        // Stop and door together: stop wins.
        phase = "stopdoor";
        stop_btn = 1'b1; door_open = 1'b1; cyc();
        stop_btn = 1'b0; cyc();
        door_open = 1'b0; timer_done = 1'b1; repeat (2) cyc();

        // Arm timeout with timer never leaving idle.
        phase = "arm_to"; mag_cnt = 0;
        press_start();
        repeat (A + 4) cyc();
        check_val("arm_to_mag", 32'(mag_cnt), 32'd0);

        // Reset mid-cook with full power, start held through reset.
        phase = "rstcook"; power = 2'd3;
        press_start();
        timer_done = 1'b0; repeat (3) cyc();
        check_val("rc_mag_before", 32'(magnetron), 32'd1);
        reset = 1'b0; start_btn = 1'b1;
        #1;
        model_reset();
        check_all("rc_async");
        cyc();
        reset = 1'b1;
        repeat (4) cyc();
        start_btn = 1'b0; cyc();
        press_start();
        press_stop();
        timer_done = 1'b1;

        // Random traffic.
        phase = "rnd";
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
            if ($urandom_range(0, 29) == 0) stop_btn = ~stop_btn;
            if ($urandom_range(0, 39) == 0) door_open = ~door_open;
            if ($urandom_range(0, 9) == 0) timer_done = ~timer_done;
            if ($urandom_range(0, 49) == 0) begin
                preset = 2'($urandom_range(0, 3));
                power  = 2'($urandom_range(0, 3));
                sw_min = 7'($urandom_range(0, 127));
                sw_sec = 7'($urandom_range(0, 127));
            end
            reset = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
            cyc();
        end
        reset = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/microwave_ctrl.md
Name: microwave_ctrl

Overview:
- Top-level sequencer for the microwave countdown timer.
- Selects the cook time from switches or presets, drives single-cycle start/pause/stop pulses into the timer and tracks the timer's done flag.
- Enforces the door interlock, duty-cycles the magnetron enable by power level and sounds a completion beep.
- Sits between the board inputs and the timer instance.

Parameters:
- PWR_PERIOD, 100000000, magnetron duty window length in clock cycles.
- BEEP_CYCLES, 150000000, length of the completion beep in clock cycles.
- ARM_TIMEOUT, 16, maximum cycles to wait for timer done to fall after a start pulse.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start_btn  input  1  start/resume button, synchronized level
- stop_btn  input  1  stop/cancel button, synchronized level
- door_open  input  1  door sensor, 1 = open
- preset  input  2  0 manual, 1 = 00:30, 2 = 01:00, 3 = 02:00
- power  input  2  power level 0..3 (25/50/75/100 %)
- sw_min  input  7  manual minutes
- sw_sec  input  7  manual seconds
- timer_done  input  1  timer idle flag (1 = idle)
- timer_start  output  1  one-cycle pulse to timer start
- timer_pause  output  1  one-cycle pulse to timer pause
- timer_stop  output  1  one-cycle pulse to timer stop
- min_set  output  7  minutes loaded into timer
- sec_set  output  7  seconds loaded into timer
- magnetron  output  1  heating element enable
- lamp  output  1  cavity lamp
- beep  output  1  buzzer enable

Behaviour:
Reset:
- reset=0 asynchronously forces state IDLE, all outputs 0, all counters 0 and the edge-detect registers 0.

Button and door events:
- start_btn and stop_btn are rising-edge detected internally: one event per press, 1 cycle after the input rises.
- door_open is used as a level.
- Pulse outputs are registered and exactly 1 cycle wide; at most one pulse is asserted per cycle.

Time selection (IDLE only; min_set/sec_set are frozen in all other states):
- preset 0: min_set = min(sw_min, 99), sec_set = min(sw_sec, 59).
- preset 1: min_set = 0, sec_set = 30.
- preset 2: min_set = 1, sec_set = 0.
- preset 3: min_set = 2, sec_set = 0.

Power:
- Power level is latched on leaving IDLE.

States:
- IDLE:
  - start event with door closed -> timer_start pulse; go to ARM.
  - start event with door open is ignored.
- ARM:
  - Wait for timer_done=0 -> COOK.
  - If ARM_TIMEOUT cycles pass without that -> IDLE with no pulse.
  - stop event -> timer_stop pulse; go to IDLE.
- COOK (priority order):
  - stop event -> timer_stop pulse; go to IDLE.
  - door_open=1 -> timer_pause pulse; go to DOOR_PAUSE.
  - timer_done=1 -> DONE.
- DOOR_PAUSE:
  - stop event -> timer_stop pulse; go to IDLE.
  - start event with door closed -> timer_pause pulse (resume); go to COOK.
  - start event with door open is ignored.
- DONE:
  - beep=1 for BEEP_CYCLES cycles, then IDLE.
  - A start or stop event ends the beep immediately -> IDLE. Such an event does not also restart cooking.

Magnetron:
- Window counter runs 0..PWR_PERIOD-1 and wraps. It is cleared on entering COOK and frozen outside COOK.
- magnetron = 1 only in COOK while counter < (PWR_PERIOD/4)*(power_latched+1).
- Power level 3 gives a constant 1.
- magnetron is forced to 0 in the same cycle door_open rises.
- It is never 1 outside COOK or while door_open=1.

Lamp:
- lamp = 1 in COOK or DOOR_PAUSE, or while door_open=1.

Width and arithmetic:
- Counters are 32 bit.
- All comparisons are unsigned.

Test Plan:
1. Reset mid-cook: drive reset=0 while in COOK with magnetron=1 -> all outputs 0 in the same cycle; after release the block is in IDLE and ignores a held start_btn until it is released and pressed again.
2. Preset 1, power 3, door closed, start press -> min_set=0 and sec_set=30 before the pulse; one timer_start pulse; ARM; timer_done drops -> COOK with magnetron constantly 1 and lamp=1; timer_done rises -> beep for exactly BEEP_CYCLES, then IDLE.
3. Manual sw_min=120, sw_sec=75 -> min_set=99, sec_set=59; power 1 with PWR_PERIOD=8 in simulation -> magnetron high 4 of every 8 cycles.
4. Door opened during COOK -> magnetron=0 the same cycle, one timer_pause pulse, DOOR_PAUSE.
   - Start press with door still open -> no pulse.
   - Close door, start press -> one timer_pause pulse; COOK; window counter restarts at 0.
5. Stop and door_open asserted in the same COOK cycle -> only timer_stop pulses; state IDLE; no timer_pause pulse.
6. Start press, timer_done held at 1 -> after ARM_TIMEOUT cycles return to IDLE; magnetron never asserted.
